// File: rtl/parity_check_rx.sv
// Serial even-parity frame receiver.
// A frame is DATA_W data bits sent LSB first, followed by one even-parity bit.
// A frame is aborted when TIMEOUT consecutive idle cycles occur mid-frame.
module parity_check_rx #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              out_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int GAP_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   bit_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic               run_par;
  logic [DATA_W-1:0]  shreg;
  logic               timeout_hit;

  // Abort condition: this idle cycle brings the gap count up to TIMEOUT.
  always_comb begin
    timeout_hit = 1'b0;
    if ((state != IDLE) && !bit_valid && (gap_cnt == GAP_W'(TIMEOUT - 1)))
      timeout_hit = 1'b1;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bit_valid)
          state_next = DATA;
      end
      DATA: begin
        if (bit_valid) begin
          if (bit_cnt == CNT_W'(DATA_W - 1))
            state_next = PARITY;
        end else if (timeout_hit) begin
          state_next = IDLE;
        end
      end
      PARITY: begin
        if (bit_valid || timeout_hit)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output decode from the state.
  always_comb begin
    busy = 1'b0;
    if ((state == DATA) || (state == PARITY))
      busy = 1'b1;
  end

  // Frame assembly, gap counting, result registers and one-cycle pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      run_par    <= 1'b0;
      shreg      <= '0;
      data_out   <= '0;
      out_valid  <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      frame_err <= 1'b0;

      if (bit_valid || (state == IDLE))
        gap_cnt <= '0;
      else if (timeout_hit)
        gap_cnt <= '0;
      else
        gap_cnt <= gap_cnt + 1'b1;

      if (timeout_hit)
        frame_err <= 1'b1;

      if (bit_valid) begin
        case (state)
          IDLE: begin
            // Start of frame: the shift register is cleared so later bits can be OR-ed in.
            shreg   <= DATA_W'(bit_in);
            run_par <= bit_in;
            bit_cnt <= CNT_W'(1);
          end
          DATA: begin
            shreg   <= shreg | (DATA_W'(bit_in) << bit_cnt);
            run_par <= run_par ^ bit_in;
            bit_cnt <= bit_cnt + 1'b1;
          end
          PARITY: begin
            data_out   <= shreg;
            parity_err <= run_par ^ bit_in;
            out_valid  <= 1'b1;
            bit_cnt    <= '0;
            run_par    <= 1'b0;
          end
          default: ;
        endcase
      end else if (timeout_hit) begin
        bit_cnt <= '0;
        run_par <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_parity_check_rx.sv
// Directed bench for parity_check_rx (DATA_W=8, TIMEOUT=4).
module tb_parity_check_rx;

  logic       clk;
  logic       rst;
  logic       bit_in;
  logic       bit_valid;
  logic [7:0] data_out;
  logic       out_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  int total = 0;
  int bad   = 0;

  parity_check_rx #(.DATA_W(8), .TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .data_out   (data_out),
    .out_valid  (out_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs at a falling edge, then wait for the next falling edge so the
  // outputs seen afterwards reflect the rising edge that sampled these inputs.
  task automatic cyc(input logic v, input logic b);
    bit_valid = v;
    bit_in    = b;
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Send 8 data bits LSB first plus parity bit p; check no pulses while in flight.
  task automatic send_frame(input string tag, input logic [7:0] d, input logic p);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, d[i]);
      chk({tag, "_ov_mid"}, {31'd0, out_valid}, 32'd0);
      chk({tag, "_fe_mid"}, {31'd0, frame_err}, 32'd0);
      chk({tag, "_busy_mid"}, {31'd0, busy}, 32'd1);
    end
    cyc(1'b1, p);
  endtask

  task automatic chk_done(input string tag, input logic [7:0] d, input logic perr);
    chk({tag, "_ov"},   {31'd0, out_valid},  32'd1);
    chk({tag, "_data"}, {24'd0, data_out},   {24'd0, d});
    chk({tag, "_perr"}, {31'd0, parity_err}, {31'd0, perr});
    chk({tag, "_busy"}, {31'd0, busy},       32'd0);
    chk({tag, "_fe"},   {31'd0, frame_err},  32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    bit_in    = 1'b1;
    bit_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);

    // Reset values, with bit_valid held high to show reset overrides it.
    chk("rst_data", {24'd0, data_out}, 32'd0);
    chk("rst_ov",   {31'd0, out_valid}, 32'd0);
    chk("rst_perr", {31'd0, parity_err}, 32'd0);
    chk("rst_fe",   {31'd0, frame_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    cyc(1'b0, 1'b1);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // Good frame 0xA5, parity 0.
    send_frame("good", 8'hA5, 1'b0);
    chk_done("good", 8'hA5, 1'b0);
    cyc(1'b0, 1'b0);
    chk("good_ov_clr", {31'd0, out_valid}, 32'd0);

    // Bad parity 0xA5, parity 1; result must hold through idle cycles.
    send_frame("badp", 8'hA5, 1'b1);
    chk_done("badp", 8'hA5, 1'b1);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1);
    chk("hold_perr", {31'd0, parity_err}, 32'd1);
    chk("hold_data", {24'd0, data_out}, 32'h0000_00A5);
    chk("hold_ov",   {31'd0, out_valid}, 32'd0);

    // Back-to-back 0x00 then 0xFF with bit_valid never dropped.
    send_frame("b2b0", 8'h00, 1'b0);
    chk_done("b2b0", 8'h00, 1'b0);
    send_frame("b2b1", 8'hFF, 1'b0);
    chk_done("b2b1", 8'hFF, 1'b0);
    cyc(1'b0, 1'b0);

    // 0x3C with 3 idle cycles between bits 4 and 5; bit_in toggles while idle.
    for (int i = 0; i < 5; i++) cyc(1'b1, (8'h3C >> i) & 8'h01 ? 1'b1 : 1'b0);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    chk("gap_busy", {31'd0, busy}, 32'd1);
    chk("gap_fe",   {31'd0, frame_err}, 32'd0);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    chk_done("gap", 8'h3C, 1'b0);

    // Timeout: 3 bits then 4 idle cycles.
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1);
    chk("to_fe_early", {31'd0, frame_err}, 32'd0);
    chk("to_busy_early", {31'd0, busy}, 32'd1);
    cyc(1'b0, 1'b1);
    chk("to_fe",   {31'd0, frame_err}, 32'd1);
    chk("to_ov",   {31'd0, out_valid}, 32'd0);
    chk("to_busy", {31'd0, busy}, 32'd0);
    chk("to_data", {24'd0, data_out}, 32'h0000_003C);
    chk("to_perr", {31'd0, parity_err}, 32'd0);
    cyc(1'b0, 1'b0);
    chk("to_fe_clr", {31'd0, frame_err}, 32'd0);

    // Reset mid-frame, then a full 0x81 frame.
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1);
    rst = 1'b1;
    cyc(1'b1, 1'b1);
    rst = 1'b0;
    chk("mrst_ov",   {31'd0, out_valid}, 32'd0);
    chk("mrst_fe",   {31'd0, frame_err}, 32'd0);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_data", {24'd0, data_out}, 32'd0);
    send_frame("mrst", 8'h81, 1'b0);
    chk_done("mrst", 8'h81, 1'b0);
    cyc(1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
